// File: rtl/knight_rider_pkg.sv
// Shared constants, FSM encoding and ring-index to LED mapping for the Knight Rider decoder.
package knight_rider_pkg;

  localparam int unsigned RING_W = 14;
  localparam int unsigned LED_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRACK = 2'b01,
    ST_FAULT = 2'b10
  } kr_state_e;

  // Ring 0..7 walk up the LED bar, ring 8..13 walk back down over bits 6..1.
  function automatic logic [LED_W-1:0] idx_to_led(input logic [3:0] idx);
    logic [LED_W-1:0] led;
    led = '0;
    if (idx < 4'd8) begin
      led[idx[2:0]] = 1'b1;
    end else if (idx < 4'd14) begin
      led[3'(4'd14 - idx)] = 1'b1;
    end
    return led;
  endfunction

  function automatic logic idx_to_dir(input logic [3:0] idx);
    return (idx >= 4'd7);
  endfunction

endpackage

// File: rtl/kr_onehot_idx.sv
// Combinational one-hot ring vector to binary index, with a one-hot-valid flag.
module kr_onehot_idx
  import knight_rider_pkg::*;
(
  input  logic [RING_W-1:0] ring_i,
  output logic [3:0]        idx_o,
  output logic              valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = $onehot(ring_i);
    for (int unsigned k = 0; k < RING_W; k++) begin
      if (ring_i[k]) idx_o = 4'(k);
    end
  end

endmodule

// File: rtl/knight_rider_decoder.sv
// Decodes a 14-bit one-hot ring counter into an 8-LED Knight Rider sweep,
// tracking sweep count and latching a sticky fault on illegal ring sequences.
module knight_rider_decoder
  import knight_rider_pkg::*;
#(
  parameter int unsigned SWEEP_W   = 8,
  parameter int unsigned RECOVER_N = 14
) (
  input  logic               clk_i,
  input  logic               sys_rst_ni,
  input  logic [RING_W-1:0]  ring_i,
  input  logic               hold_i,
  output logic [LED_W-1:0]   led_o,
  output logic               dir_o,
  output logic [SWEEP_W-1:0] sweep_cnt_o,
  output logic               err_o,
  output logic [1:0]         state_o
);

  localparam int unsigned      REC_W    = $clog2(RECOVER_N + 1);
  localparam logic [REC_W-1:0] REC_LAST = REC_W'(RECOVER_N - 1);

  kr_state_e          state_q, state_d;
  logic [RING_W-1:0]  r_prev;
  logic [REC_W-1:0]   rec_q, rec_d;
  logic [LED_W-1:0]   led_nxt, led_d;
  logic               dir_nxt, dir_d;
  logic [SWEEP_W-1:0] sweep_d;
  logic               err_d;
  logic [3:0]         idx;
  logic               valid;
  logic               legal_adv, legal_stall;

  kr_onehot_idx u_onehot_idx (
    .ring_i  (ring_i),
    .idx_o   (idx),
    .valid_o (valid)
  );

  assign legal_adv   = valid && (ring_i == {r_prev[RING_W-2:0], r_prev[RING_W-1]});
  assign legal_stall = valid && (ring_i == r_prev);
  assign state_o     = state_q;

  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    sweep_d = sweep_cnt_o;
    err_d   = err_o;
    led_nxt = led_o;
    dir_nxt = dir_o;
    unique case (state_q)
      ST_IDLE: begin
        led_nxt = '0;
        if (valid) begin
          state_d = ST_TRACK;
          led_nxt = idx_to_led(idx);
          dir_nxt = idx_to_dir(idx);
        end
      end
      ST_TRACK: begin
        if (legal_adv || legal_stall) begin
          led_nxt = idx_to_led(idx);
          dir_nxt = idx_to_dir(idx);
          // Advancing onto bit 0 can only come from bit 13: one full sweep done.
          if (legal_adv && ring_i[0]) sweep_d = sweep_cnt_o + SWEEP_W'(1);
        end else begin
          state_d = ST_FAULT;
          err_d   = 1'b1;
          led_nxt = '0;
        end
      end
      ST_FAULT: begin
        led_nxt = '0;
        if (legal_adv) begin
          if (rec_q == REC_LAST) begin
            state_d = ST_TRACK;
            rec_d   = '0;
            led_nxt = idx_to_led(idx);
            dir_nxt = idx_to_dir(idx);
          end else begin
            rec_d = rec_q + REC_W'(1);
          end
        end else if (!legal_stall) begin
          rec_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Hold only freezes the visible pattern; tracking and fault logic keep running.
    led_d = hold_i ? led_o : led_nxt;
    dir_d = hold_i ? dir_o : dir_nxt;
  end

  always_ff @(posedge clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      state_q     <= ST_IDLE;
      r_prev      <= '0;
      rec_q       <= '0;
      led_o       <= '0;
      dir_o       <= 1'b0;
      sweep_cnt_o <= '0;
      err_o       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_prev      <= ring_i;
      rec_q       <= rec_d;
      led_o       <= led_d;
      dir_o       <= dir_d;
      sweep_cnt_o <= sweep_d;
      err_o       <= err_d;
    end
  end

endmodule

// File: tb/tb_knight_rider_decoder.sv
// Self-checking bench for knight_rider_decoder: directed scenarios plus a
// randomized run against an index-based reference model.
module tb_knight_rider_decoder;

  localparam int SWEEP_W   = 8;
  localparam int RECOVER_N = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] ring = '0;
  logic        hold = 1'b0;
  logic [7:0]  led;
  logic        dir;
  logic [SWEEP_W-1:0] sweep;
  logic        err;
  logic [1:0]  st;

  int checks = 0;
  int errors = 0;
  int cur = 0;

  // Reference model: positions as integers, modes 0=IDLE 1=TRACK 2=FAULT.
  int         m_mode, m_prev, m_sweep, m_rec;
  logic [7:0] m_led;
  logic       m_dir, m_err;

  knight_rider_decoder #(.SWEEP_W(SWEEP_W), .RECOVER_N(RECOVER_N)) dut (
    .clk_i       (clk),
    .sys_rst_ni  (rst_n),
    .ring_i      (ring),
    .hold_i      (hold),
    .led_o       (led),
    .dir_o       (dir),
    .sweep_cnt_o (sweep),
    .err_o       (err),
    .state_o     (st)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    int b;
    logic [7:0] v;
    b = (i < 8) ? i : 14 - i;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic int onehot_index(input logic [13:0] v);
    int n = 0;
    int p = -1;
    for (int i = 0; i < 14; i++) if (v[i]) begin n++; p = i; end
    return (n == 1) ? p : -1;
  endfunction

  function automatic logic [13:0] at(input int i);
    logic [13:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = -1; m_sweep = 0; m_rec = 0;
    m_led = '0; m_dir = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic [13:0] s, input logic h);
    int ci;
    bit adv, stall;
    logic [7:0] nl;
    logic nd;
    ci    = onehot_index(s);
    adv   = (ci >= 0) && (m_prev >= 0) && (ci == (m_prev + 1) % 14);
    stall = (ci >= 0) && (ci == m_prev);
    nl = m_led;
    nd = m_dir;
    if (m_mode == 0) begin
      nl = '0;
      if (ci >= 0) begin m_mode = 1; nl = pat(ci); nd = (ci >= 7); end
    end else if (m_mode == 1) begin
      if (adv || stall) begin
        nl = pat(ci); nd = (ci >= 7);
        if (adv && ci == 0) m_sweep = (m_sweep + 1) % (1 << SWEEP_W);
      end else begin
        m_mode = 2; m_err = 1'b1; nl = '0;
      end
    end else begin
      nl = '0;
      if (adv) begin
        m_rec++;
        if (m_rec == RECOVER_N) begin m_mode = 1; m_rec = 0; nl = pat(ci); nd = (ci >= 7); end
      end else if (!stall) begin
        m_rec = 0;
      end
    end
    if (!h) begin m_led = nl; m_dir = nd; end
    m_prev = ci;
  endtask

  task automatic step(input logic [13:0] s, input logic h);
    ring = s;
    hold = h;
    @(posedge clk);
    model_step(s, h);
    #1;
  endtask

  task automatic advance(input int n, input logic h);
    for (int i = 0; i < n; i++) begin
      cur = (cur + 1) % 14;
      step(at(cur), h);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ring = '0; hold = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h want 00", led); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %b want 0", dir); end
    checks++; if (sweep !== '0) begin errors++; $display("FAIL reset_sweep: got %0d want 0", sweep); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (st !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", st); end
    rst_n = 1'b1;
    step(14'h0000, 1'b0);
    checks++; if (st !== 2'b00 || led !== 8'h00) begin
      errors++; $display("FAIL idle_zero_sample: state %b led %h want 00/00", st, led);
    end
  endtask

  task automatic test_sweep();
    cur = 0;
    step(at(0), 1'b0);
    checks++; if (st !== 2'b01 || led !== 8'h01) begin
      errors++; $display("FAIL sweep_enter: state %b led %h want 01/01", st, led);
    end
    for (int i = 0; i < 28; i++) begin
      advance(1, 1'b0);
      checks++; if (led !== m_led) begin errors++; $display("FAIL sweep_led idx %0d: got %h want %h", cur, led, m_led); end
      checks++; if (dir !== m_dir) begin errors++; $display("FAIL sweep_dir idx %0d: got %b want %b", cur, dir, m_dir); end
      checks++; if (sweep !== SWEEP_W'(m_sweep)) begin errors++; $display("FAIL sweep_cnt idx %0d: got %0d want %0d", cur, sweep, m_sweep); end
    end
    checks++; if (sweep !== 8'd2) begin errors++; $display("FAIL sweep_total: got %0d want 2", sweep); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sweep_err: got %b want 0", err); end
  endtask

  task automatic test_fault();
    advance(5, 1'b0);
    step(14'h0003, 1'b0);
    checks++; if (st !== 2'b10) begin errors++; $display("FAIL fault_state: got %b want 10", st); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL fault_err: got %b want 1", err); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL fault_led: got %h want 00", led); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL fault_dir_hold: got %b want 0", dir); end
    cur = 6;
    step(at(cur), 1'b0);
    advance(RECOVER_N - 1, 1'b0);
    checks++; if (st !== 2'b10) begin errors++; $display("FAIL fault_early_exit: got %b want 10", st); end
    advance(1, 1'b0);
    checks++; if (st !== 2'b01) begin errors++; $display("FAIL fault_recover: got %b want 01", st); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b want 1", err); end
    checks++; if (led !== m_led) begin errors++; $display("FAIL fault_recover_led: got %h want %h", led, m_led); end
  endtask

  task automatic test_recovery_restart();
    step(14'h0000, 1'b0);
    checks++; if (st !== 2'b10) begin errors++; $display("FAIL restart_enter: got %b want 10", st); end
    cur = 7;
    step(at(cur), 1'b0);
    advance(10, 1'b0);
    checks++; if (st !== 2'b10) begin errors++; $display("FAIL restart_after10: got %b want 10", st); end
    cur = 5;
    step(at(cur), 1'b0);
    checks++; if (st !== 2'b10) begin errors++; $display("FAIL restart_skip: got %b want 10", st); end
    advance(RECOVER_N - 1, 1'b0);
    checks++; if (st !== 2'b10) begin errors++; $display("FAIL restart_count_kept: got %b want 10", st); end
    advance(1, 1'b0);
    checks++; if (st !== 2'b01) begin errors++; $display("FAIL restart_recover: got %b want 01", st); end
  endtask

  task automatic test_hold();
    advance(11, 1'b0);
    checks++; if (led !== 8'h04) begin errors++; $display("FAIL hold_start: got %h want 04", led); end
    for (int i = 0; i < 6; i++) begin
      advance(1, 1'b1);
      checks++; if (led !== 8'h04 || dir !== 1'b0) begin
        errors++; $display("FAIL hold_freeze idx %0d: led %h dir %b want 04/0", cur, led, dir);
      end
    end
    step(at(cur), 1'b0);
    checks++; if (led !== 8'h40) begin errors++; $display("FAIL hold_release_led: got %h want 40", led); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL hold_release_dir: got %b want 1", dir); end
  endtask

  task automatic test_stall();
    int sw;
    advance(10, 1'b0);
    sw = m_sweep;
    for (int i = 0; i < 4; i++) begin
      step(14'h0010, 1'b0);
      checks++; if (led !== 8'h10 || st !== 2'b01) begin
        errors++; $display("FAIL stall_hold: led %h state %b want 10/01", led, st);
      end
      checks++; if (sweep !== SWEEP_W'(sw)) begin errors++; $display("FAIL stall_sweep: got %0d want %0d", sweep, sw); end
    end
  endtask

  task automatic test_random();
    int r;
    logic [13:0] s;
    logic h;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 72) begin
        cur = (cur + 1) % 14; s = at(cur);
      end else if (r < 82) begin
        s = at(cur);
      end else if (r < 91) begin
        s = 14'($urandom);
      end else begin
        cur = $urandom_range(0, 13); s = at(cur);
      end
      h = ($urandom_range(0, 9) == 0);
      step(s, h);
      checks++; if (led !== m_led) begin errors++; $display("FAIL rand_led cyc %0d: got %h want %h", i, led, m_led); end
      checks++; if (dir !== m_dir) begin errors++; $display("FAIL rand_dir cyc %0d: got %b want %b", i, dir, m_dir); end
      checks++; if (st !== 2'(m_mode)) begin errors++; $display("FAIL rand_state cyc %0d: got %b want %0d", i, st, m_mode); end
      checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err cyc %0d: got %b want %b", i, err, m_err); end
      checks++; if (sweep !== SWEEP_W'(m_sweep)) begin errors++; $display("FAIL rand_sweep cyc %0d: got %0d want %0d", i, sweep, m_sweep); end
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cur = 0;
    step(at(0), 1'b0);
    advance(42, 1'b0);
    checks++; if (sweep !== 8'd3) begin errors++; $display("FAIL midrst_pre_sweep: got %0d want 3", sweep); end
    advance(3, 1'b0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (led !== 8'h00 || dir !== 1'b0) begin errors++; $display("FAIL midrst_led_dir: got %h/%b want 00/0", led, dir); end
    checks++; if (sweep !== '0 || err !== 1'b0) begin errors++; $display("FAIL midrst_cnt_err: got %0d/%b want 0/0", sweep, err); end
    checks++; if (st !== 2'b00) begin errors++; $display("FAIL midrst_state: got %b want 00", st); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cur = 9;
    step(at(cur), 1'b0);
    checks++; if (st !== 2'b01) begin errors++; $display("FAIL midrst_restart_state: got %b want 01", st); end
    checks++; if (led !== 8'h20 || dir !== 1'b1) begin errors++; $display("FAIL midrst_restart_led: got %h/%b want 20/1", led, dir); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sweep();
    test_fault();
    test_recovery_restart();
    test_hold();
    test_stall();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/knight_rider_decoder.md
KNIGHT_RIDER_DECODER -- requirements
Module: knight_rider_decoder

Interface
REQ-001 Parameter SWEEP_W, default 8: width of the completed-sweep counter.
REQ-002 Parameter RECOVER_N, default 14: number of consecutive legal advances required to leave FAULT.
REQ-003 Port clk_i, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port sys_rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 Port ring_i, input, 14: one-hot vector from the 14-bit ring counter; bit k set means ring position k.
REQ-006 Port hold_i, input, 1: freeze led_o and dir_o while high.
REQ-007 Port led_o, output, 8: Knight Rider LED pattern, registered.
REQ-008 Port dir_o, output, 1: 0 = sweeping toward led_o[7], 1 = sweeping toward led_o[0].
REQ-009 Port sweep_cnt_o, output, SWEEP_W: number of completed full sweeps (ring wrap 13->0), wraps modulo 2^SWEEP_W.
REQ-010 Port err_o, output, 1: sticky fault flag; cleared only by reset.
REQ-011 Port state_o, output, 2: current FSM state encoding.

Function
REQ-012 The block SHALL register ring_i each cycle into a previous-sample register r_prev.
REQ-013 Position mapping SHALL be: ring index k in 0..7 -> led bit k; ring index k in 8..13 -> led bit 14-k (6..1).
REQ-014 dir_o SHALL be 0 for ring index 0..6 and 1 for ring index 7..13.
REQ-015 led_o and dir_o SHALL reflect the ring_i value sampled one clock earlier (latency 1 cycle), except as given in REQ-020 and REQ-021.
REQ-016 A sample is legal-advance when it is one-hot and equals r_prev rotated left by one (bit 13 wraps to bit 0); legal-stall when it equals r_prev and is one-hot.
REQ-017 The FSM SHALL have states IDLE (00), TRACK (01), FAULT (10).
REQ-018 IDLE -> TRACK on the first one-hot sample; IDLE stays on any non-one-hot sample; led_o = 0 in IDLE.
REQ-019 TRACK -> FAULT on any sample that is neither legal-advance nor legal-stall; err_o SHALL set in the same cycle the transition occurs.
REQ-020 In FAULT, led_o SHALL be 8'h00 and dir_o SHALL hold its last TRACK value.
REQ-021 FAULT -> TRACK after RECOVER_N consecutive legal-advance samples; any illegal sample resets the recovery count to 0; legal-stall leaves the count unchanged.
REQ-022 sweep_cnt_o SHALL increment by 1 on each legal-advance from index 13 to index 0 in TRACK only; not in IDLE or FAULT.
REQ-023 While hold_i is high, led_o and dir_o SHALL keep their values; FSM, r_prev, fault detection and sweep_cnt_o continue to update.
REQ-024 On hold_i falling, led_o SHALL show the mapping of the most recent sample on the next cycle.
REQ-025 A legal-stall in TRACK SHALL leave all outputs unchanged.

Reset
REQ-026 On sys_rst_ni low: led_o = 0, dir_o = 0, sweep_cnt_o = 0, err_o = 0, state = IDLE, r_prev = 0, recovery count = 0, asynchronously.
REQ-027 Reset asserted mid-sweep or in FAULT SHALL return to the REQ-026 values within the same cycle; after release, behaviour restarts from IDLE.

Structure
REQ-028 Package knight_rider_pkg SHALL hold RING_W = 14, LED_W = 8, the state enum, and the index-to-LED mapping function.
REQ-029 One sub-module, kr_onehot_idx, SHALL convert ring_i to a 4-bit index plus a one-hot-valid flag (combinational); it is instantiated once.

Verification
REQ-030 Reset, then ring_i = 14'h0001 stepping rotate-left each cycle for 28 cycles -> led_o sequence 01,02,04,...,80,40,...,02,01,... one cycle delayed; sweep_cnt_o = 2; err_o = 0.
REQ-031 In TRACK at index 5, drive ring_i = 14'h0003 -> next cycle state_o = FAULT, err_o = 1, led_o = 0; then 14 legal advances -> state_o = TRACK, err_o stays 1.
REQ-032 In FAULT after 10 legal advances, inject a skip (index 3 -> 5) -> recovery restarts; TRACK reached only after 14 further legal advances.
REQ-033 hold_i high at index 2 for 6 cycles -> led_o stays 8'h04; on hold_i low, led_o = mapping of current index (index 8 -> 8'h40) next cycle.
REQ-034 ring_i repeated 14'h0010 for 4 cycles in TRACK -> led_o stays 8'h10, no fault, sweep_cnt_o unchanged.
REQ-035 sys_rst_ni low for 1 cycle mid-sweep with sweep_cnt_o = 3 -> all outputs zero immediately, state_o = IDLE; first one-hot sample after release -> TRACK.
